// File: rtl/ir_command_queue.sv
// NEC frame checker and show-ahead command FIFO fed by IR_Receiver.
// Optional duplicate suppression is built only when IR_DUP_FILTER_EN is defined.
module ir_command_queue #(
  parameter int FIFO_DEPTH     = 4,
  parameter bit CHECK_ADDRESS  = 1'b1,
  parameter int HOLDOFF_CYCLES = 5400000
) (
  input  logic                          i_CLOCK_POS,
  input  logic                          i_RESET_POS,
  input  logic [31:0]                   i_DATA,
  input  logic                          i_DATA_READY,
  input  logic                          i_CMD_READY,
  output logic                          o_CMD_VALID,
  output logic [7:0]                    o_CMD,
  output logic [15:0]                   o_ADDR,
  output logic [31:0]                   o_LAST_FRAME,
  output logic                          o_ERROR,
  output logic                          o_OVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_COUNT,
  output logic                          o_FSM_STATE
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE = 1'b0, CHECK = 1'b1} state_t;

  state_t        state, next_state;
  logic          prev_ready, armed, rise;
  logic [31:0]   capture;
  logic          frame_ok, suppress, accept, error_next;
  logic          full, pop, do_push;
  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   addr_in;

  // armed stays low for the first clock after reset so a level held high
  // through reset release is absorbed into prev_ready instead of captured.
  assign rise = armed & i_DATA_READY & ~prev_ready;

  assign frame_ok = (capture[31:24] == ~capture[23:16]) &&
                    (!CHECK_ADDRESS || (capture[15:8] == ~capture[7:0]));
  assign addr_in  = CHECK_ADDRESS ? {8'h00, capture[7:0]} : capture[15:0];

  // Output handshake: an entry transfers on any clock where o_CMD_VALID and
  // i_CMD_READY are both high; o_CMD/o_ADDR hold the head while valid is high.
  assign o_CMD_VALID  = (count != '0);
  assign o_CMD        = o_CMD_VALID ? mem[rd_ptr][7:0]  : 8'h00;
  assign o_ADDR       = o_CMD_VALID ? mem[rd_ptr][23:8] : 16'h0000;
  assign o_FIFO_COUNT = count;
  assign o_FSM_STATE  = (state == CHECK);

  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = o_CMD_VALID & i_CMD_READY;
  assign do_push = accept & (~full | pop);

`ifdef IR_DUP_FILTER_EN
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  logic [HW-1:0] holdoff_cnt;
  logic          seen_frame;

  assign suppress = seen_frame && (capture == o_LAST_FRAME) &&
                    (holdoff_cnt < HW'(HOLDOFF_CYCLES));

  always_ff @(posedge i_CLOCK_POS or posedge i_RESET_POS) begin
    if (i_RESET_POS) begin
      holdoff_cnt <= '0;
      seen_frame  <= 1'b0;
    end else if (accept) begin
      holdoff_cnt <= '0;
      seen_frame  <= 1'b1;
    end else if (holdoff_cnt < HW'(HOLDOFF_CYCLES)) begin
      holdoff_cnt <= holdoff_cnt + HW'(1);
    end
  end
`else
  logic unused_holdoff;
  assign unused_holdoff = ^HOLDOFF_CYCLES;
  assign suppress       = 1'b0;
`endif

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    error_next = 1'b0;
    case (state)
      IDLE:  if (rise) next_state = CHECK;
      CHECK: begin
        next_state = IDLE;
        accept     = frame_ok & ~suppress;
        error_next = ~frame_ok;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_CLOCK_POS or posedge i_RESET_POS) begin
    if (i_RESET_POS) begin
      state        <= IDLE;
      prev_ready   <= 1'b0;
      armed        <= 1'b0;
      capture      <= '0;
      o_LAST_FRAME <= '0;
      o_ERROR      <= 1'b0;
      o_OVERFLOW   <= 1'b0;
    end else begin
      state      <= next_state;
      prev_ready <= i_DATA_READY;
      armed      <= 1'b1;
      o_ERROR    <= error_next;
      if (state == IDLE && rise) capture <= i_DATA;
      if (accept) o_LAST_FRAME <= capture;
      if (accept && full && !pop) o_OVERFLOW <= 1'b1;
    end
  end

  always_ff @(posedge i_CLOCK_POS or posedge i_RESET_POS) begin
    if (i_RESET_POS) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= {addr_in, capture[23:16]};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
